// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that keeps a small queue of fetched words in front of decode.
// It honours the MIPS branch delay slot on every redirect.
//
// Build option:
//   IFETCH_PREFETCH_EN  defined   -> 2-entry fetch queue (fetch continues
//                                    through a one-cycle decode stall)
//                       undefined -> single-entry fetch register
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               decode holds its current instruction
//   jump_branch         taken conditional branch in decode
//   jump_target         J/JAL in decode
//   jump_reg            JR/JALR in decode (target on jr_pc)
//   jr_pc               register jump target
//   imem_req/imem_addr  instruction-memory read request and word address
//   imem_ready          read completes this cycle, imem_rdata is valid
//   imem_rdata          fetched word
//   pc, instr           queue head presented to decode
//   instr_valid         instr is a real fetched instruction
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_branch,
    input  logic        jump_target,
    input  logic        jump_reg,
    input  logic [31:0] jr_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid
);

`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0]  DEPTH_C    = 2'(DEPTH);
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    // Queue storage: entry 0 is the head, younger entries follow in order.
    logic [31:0] q_pc_reg    [DEPTH];
    logic [31:0] q_instr_reg [DEPTH];
    logic [31:0] shift_pc    [DEPTH];
    logic [31:0] shift_instr [DEPTH];
    logic [1:0]  count_reg, count_next;

    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic        drop_reg, drop_next;             // in-flight word is stale
    logic [31:0] resume_pc_reg, resume_pc_next;   // fetch_pc once it returns
    logic        pend_valid_reg, pend_valid_next; // target waits for delay slot
    logic [31:0] pend_target_reg, pend_target_next;
    logic [31:0] last_pc_reg;

    logic        head_valid, pop, redirect, complete, outstanding;
    logic        ds_queued, ds_next, push_en;
    logic [1:0]  base_cnt;
    logic [31:0] head_pc, head_instr, seq_pc, target;

    // Value each entry takes when the head is popped.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi < DEPTH - 1) begin : g_mid
            assign shift_pc[gi]    = q_pc_reg[gi+1];
            assign shift_instr[gi] = q_instr_reg[gi+1];
        end else begin : g_last
            assign shift_pc[gi]    = q_pc_reg[gi];
            assign shift_instr[gi] = q_instr_reg[gi];
        end
    end

    assign head_valid  = (count_reg != 2'd0);
    assign head_pc     = q_pc_reg[0];
    assign head_instr  = q_instr_reg[0];
    assign pc          = head_valid ? head_pc : last_pc_reg;
    assign instr       = head_valid ? head_instr : 32'h0;
    assign instr_valid = head_valid;

    assign pop      = head_valid && !stall;
    assign redirect = pop && (jump_branch || jump_target || jump_reg);
    assign seq_pc   = head_pc + 32'd4;

    always_comb begin
        if (jump_reg)
            target = jr_pc & 32'hFFFF_FFFC;
        else if (jump_target)
            target = {seq_pc[31:28], head_instr[25:0], 2'b00};
        else
            target = seq_pc + {{14{head_instr[15]}}, head_instr[15:0], 2'b00};
    end

    // Gated by rst_n so a request in progress is abandoned the moment reset
    // asserts; a slot being popped this cycle counts as free.
    assign imem_req    = rst_n && ((count_reg < DEPTH_C) || pop);
    assign imem_addr   = fetch_pc_reg;
    assign complete    = imem_req && imem_ready;
    assign outstanding = imem_req && !imem_ready;

    // Delay slot already sitting behind the head in the queue.
`ifdef IFETCH_PREFETCH_EN
    assign ds_queued = (count_reg == 2'd2) && (q_pc_reg[1] == seq_pc);
`else
    assign ds_queued = 1'b0;
`endif
    // Delay slot is the word currently being (or about to be) requested.
    assign ds_next = !drop_reg && (fetch_pc_reg == seq_pc);

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        drop_next        = drop_reg;
        resume_pc_next   = resume_pc_reg;
        pend_valid_next  = pend_valid_reg;
        pend_target_next = pend_target_reg;
        push_en          = 1'b0;
        base_cnt         = count_reg - {1'b0, pop};
        if (redirect) begin
            if (ds_queued) begin
                // Keep the delay slot, drop everything younger.
                base_cnt        = 2'd1;
                pend_valid_next = 1'b0;
                if (outstanding) begin
                    drop_next      = 1'b1;
                    resume_pc_next = target;
                end else begin
                    drop_next     = 1'b0;
                    fetch_pc_next = target;
                end
            end else if (ds_next) begin
                base_cnt = 2'd0;
                if (complete) begin
                    push_en         = 1'b1;
                    fetch_pc_next   = target;
                    pend_valid_next = 1'b0;
                end else begin
                    pend_valid_next  = 1'b1;
                    pend_target_next = target;
                end
            end else begin
                // Delay slot not fetched yet: refetch it, then the target.
                base_cnt         = 2'd0;
                pend_valid_next  = 1'b1;
                pend_target_next = target;
                if (outstanding) begin
                    drop_next      = 1'b1;
                    resume_pc_next = seq_pc;
                end else begin
                    drop_next     = 1'b0;
                    fetch_pc_next = seq_pc;
                end
            end
        end else if (complete) begin
            if (drop_reg) begin
                drop_next     = 1'b0;
                fetch_pc_next = resume_pc_reg;
            end else begin
                push_en = 1'b1;
                if (pend_valid_reg) begin
                    fetch_pc_next   = pend_target_reg;
                    pend_valid_next = 1'b0;
                end else begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
        end
        count_next = base_cnt + {1'b0, push_en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= 2'd0;
            fetch_pc_reg    <= RESET_ADDR;
            drop_reg        <= 1'b0;
            resume_pc_reg   <= RESET_ADDR;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= RESET_ADDR;
            last_pc_reg     <= RESET_ADDR;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_reg[i]    <= RESET_ADDR;
                q_instr_reg[i] <= 32'h0;
            end
        end else begin
            count_reg       <= count_next;
            fetch_pc_reg    <= fetch_pc_next;
            drop_reg        <= drop_next;
            resume_pc_reg   <= resume_pc_next;
            pend_valid_reg  <= pend_valid_next;
            pend_target_reg <= pend_target_next;
            if (pop)
                last_pc_reg <= head_pc;
            for (int i = 0; i < DEPTH; i++) begin
                if (push_en && (base_cnt == 2'(i))) begin
                    q_pc_reg[i]    <= fetch_pc_reg;
                    q_instr_reg[i] <= imem_rdata;
                end else if (pop) begin
                    q_pc_reg[i]    <= shift_pc[i];
                    q_instr_reg[i] <= shift_instr[i];
                end
            end
        end
    end

endmodule
